// File: rtl/act_quant_absmax_if.sv
`default_nettype none
// ============================================================================
//  Module   : act_quant_absmax_if
//  Purpose  : Request/result bundle between the activation quantizer and its
//             producer/consumer (start/enable in, quantized vector out).
//  Revision : 1.0 - initial release
// ============================================================================
interface act_quant_absmax_if #(
   parameter int ARR_WIDTH = 4,
   parameter int FXP_N     = 16,
   parameter int Q_BITS    = 8
);
   logic                                enable;
   logic                                start;
   logic [ARR_WIDTH-1:0][FXP_N-1:0]     input_arr;
   logic [ARR_WIDTH-1:0][Q_BITS-1:0]    q_arr;
   logic [FXP_N-1:0]                    absmax;
   logic                                busy;
   logic                                done;

   modport master (
      output enable, start, input_arr,
      input  q_arr, absmax, busy, done
   );

   modport slave (
      input  enable, start, input_arr,
      output q_arr, absmax, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/act_quant_absmax.sv
`default_nettype none
// ============================================================================
//  Module   : act_quant_absmax
//  Purpose  : Per-token absmax activation quantizer. Scans |x_i| for the max,
//             computes k = floor((QMAX << K_FRAC) / absmax) with a restoring
//             divider, then emits q_i = clamp(round(x_i * k / 2^K_FRAC)).
//             The input fraction width FXP_R cancels in the ratio.
//  Revision : 1.0 - initial release
// ============================================================================
module act_quant_absmax #(
   parameter int ARR_WIDTH = 4,
   parameter int FXP_N     = 16,
   parameter int FXP_R     = 8,
   parameter int Q_BITS    = 8,
   parameter int K_FRAC    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   act_quant_absmax_if.slave bus
);
   localparam int QMAX = (1 << (Q_BITS - 1)) - 1;
   localparam int KW   = Q_BITS + K_FRAC;
   localparam int IW   = $clog2(ARR_WIDTH);
   localparam int IDXW = IW + 1;
   localparam int DCW  = $clog2(KW);
   localparam int PW   = FXP_N + KW + 1;

   localparam logic [KW-1:0]           c_DIVIDEND = KW'(QMAX) << K_FRAC;
   localparam logic [FXP_N-1:0]        c_SAT      = {1'b0, {(FXP_N-1){1'b1}}};
   localparam logic [FXP_N-1:0]        c_MOST_NEG = {1'b1, {(FXP_N-1){1'b0}}};
   localparam logic signed [PW-1:0]    c_HALF     = PW'(1) << (K_FRAC - 1);
   localparam logic signed [PW-1:0]    c_QMAX_P   = PW'(QMAX);
   localparam logic signed [PW-1:0]    c_QMAX_N   = -PW'(QMAX);
   localparam logic [IDXW-1:0]         c_LAST     = IDXW'(ARR_WIDTH - 1);
   localparam logic [IDXW-1:0]         c_ALL      = IDXW'(ARR_WIDTH);
   localparam logic [DCW-1:0]          c_DLAST    = DCW'(KW - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ABSMAX = 3'd1,
      S_DIVIDE = 3'd2,
      S_QUANT  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                            r_state, w_state_nx;
   logic [ARR_WIDTH-1:0][FXP_N-1:0]   r_buf;
   logic [IDXW-1:0]                   r_idx;
   logic [FXP_N-1:0]                  r_run_max;
   logic [FXP_N-1:0]                  r_absmax;
   logic [FXP_N-1:0]                  r_rem;
   logic [KW-1:0]                     r_k;      // dividend bits shift out, quotient bits shift in
   logic [DCW-1:0]                    r_dcnt;
   logic signed [PW-1:0]              r_prod;   // product register, quantized one cycle later
   logic [IW-1:0]                     r_pidx;
   logic [ARR_WIDTH-1:0][Q_BITS-1:0]  r_q_arr;

   logic [IW-1:0]                     w_sel;
   logic signed [FXP_N-1:0]           w_x;
   logic [FXP_N-1:0]                  w_abs;
   logic [FXP_N-1:0]                  w_max;
   logic [FXP_N:0]                    w_rem_sh;
   logic                              w_ge;
   logic [FXP_N:0]                    w_rem_nx;
   logic signed [PW-1:0]              w_prod;
   logic signed [PW-1:0]              w_round;
   logic signed [PW-1:0]              w_qs;
   logic [Q_BITS-1:0]                 w_q;
   logic                              w_busy;
   logic                              w_done;

   // Element select, saturating absolute value, divider step and quantizer arithmetic
   always_comb begin
      w_sel    = (r_idx < c_ALL) ? r_idx[IW-1:0] : '0;
      w_x      = $signed(r_buf[w_sel]);
      if (r_buf[w_sel] == c_MOST_NEG)
         w_abs = c_SAT;
      else if (w_x < 0)
         w_abs = FXP_N'(-w_x);
      else
         w_abs = FXP_N'(w_x);
      w_max    = (w_abs > r_run_max) ? w_abs : r_run_max;

      w_rem_sh = {r_rem, r_k[KW-1]};
      w_ge     = (w_rem_sh >= {1'b0, r_absmax});
      w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_absmax}) : w_rem_sh;

      w_prod   = w_x * $signed({1'b0, r_k});
      w_round  = r_prod + c_HALF;
      w_qs     = w_round >>> K_FRAC;
      if (r_absmax == '0)
         w_q = '0;
      else if (w_qs > c_QMAX_P)
         w_q = Q_BITS'(c_QMAX_P);
      else if (w_qs < c_QMAX_N)
         w_q = Q_BITS'(c_QMAX_N);
      else
         w_q = w_qs[Q_BITS-1:0];
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nx;
   end

   // Next-state and status decode
   always_comb begin
      w_state_nx = r_state;
      w_busy     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.enable && bus.start)
               w_state_nx = S_ABSMAX;
         end
         S_ABSMAX: begin
            w_busy = 1'b1;
            if (bus.enable && r_idx == c_LAST)
               w_state_nx = (w_max == '0) ? S_QUANT : S_DIVIDE;
         end
         S_DIVIDE: begin
            w_busy = 1'b1;
            if (bus.enable && r_dcnt == c_DLAST)
               w_state_nx = S_QUANT;
         end
         S_QUANT: begin
            w_busy = 1'b1;
            if (bus.enable && r_idx == c_ALL)
               w_state_nx = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.enable && bus.start)
               w_state_nx = S_ABSMAX;
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // Datapath: capture, running max, divider iterations, pipelined quantize/write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf     <= '0;
         r_idx     <= '0;
         r_run_max <= '0;
         r_absmax  <= '0;
         r_rem     <= '0;
         r_k       <= '0;
         r_dcnt    <= '0;
         r_prod    <= '0;
         r_pidx    <= '0;
         r_q_arr   <= '0;
      end else if (bus.enable) begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  r_buf     <= bus.input_arr;
                  r_idx     <= '0;
                  r_run_max <= '0;
               end
            end
            S_ABSMAX: begin
               r_run_max <= w_max;
               if (r_idx == c_LAST) begin
                  r_absmax <= w_max;
                  r_idx    <= '0;
                  r_rem    <= '0;
                  r_dcnt   <= '0;
                  // A zero vector skips the divider; k=0 keeps every product zero
                  r_k      <= (w_max == '0) ? '0 : c_DIVIDEND;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_DIVIDE: begin
               r_rem  <= w_rem_nx[FXP_N-1:0];
               r_k    <= {r_k[KW-2:0], w_ge};
               r_dcnt <= r_dcnt + 1'b1;
            end
            S_QUANT: begin
               if (r_idx < c_ALL) begin
                  r_prod <= w_prod;
                  r_pidx <= w_sel;
               end
               if (r_idx != '0)
                  r_q_arr[r_pidx] <= w_q;
               if (r_idx != c_ALL)
                  r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.q_arr  = r_q_arr;
   assign bus.absmax = r_absmax;
   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
endmodule
`default_nettype wire

// File: tb/tb_act_quant_absmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_act_quant_absmax
//  Purpose  : Directed, table-driven bench for act_quant_absmax.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_act_quant_absmax;
   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;

   act_quant_absmax_if bus ();

   act_quant_absmax dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [63:0] x;
      logic [15:0] absmax;
      logic [23:0] k;
      logic [31:0] q;
      int          lat;
   } vec_t;

   vec_t vt[5];

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the flow wedges
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] mk4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   function automatic logic [31:0] mkq(input int a, input int b, input int c, input int d);
      return {8'(d), 8'(c), 8'(b), 8'(a)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pulse start with x, then count enabled+disabled edges until done.
   // Optional: extra start at restart_at, 5-cycle enable drop at pause_at,
   // reset at rst_at (checks cleared outputs and returns edges=-1).
   task automatic run(input logic [63:0] x, input int pause_at, input int restart_at,
                      input int rst_at, output int edges);
      @(negedge clk);
      bus.input_arr = x;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.input_arr = ~x;
      edges = 0;
      while (bus.done !== 1'b1 && edges < 200) begin
         @(posedge clk);
         #1;
         edges++;
         if (edges == 1)
            chk("busy_running", 64'(bus.busy), 64'd1);
         if (edges == restart_at) begin
            bus.start     = 1'b1;
            bus.input_arr = mk4(256, 256, 256, 256);
            @(posedge clk);
            #1;
            edges++;
            bus.start     = 1'b0;
            bus.input_arr = ~x;
         end
         if (edges == pause_at) begin
            bus.enable = 1'b0;
            repeat (5) begin
               @(posedge clk);
               edges++;
            end
            #1;
            bus.enable = 1'b1;
         end
         if (edges == rst_at) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_busy",   64'(bus.busy),   64'd0);
            chk("rst_done",   64'(bus.done),   64'd0);
            chk("rst_q_arr",  64'(bus.q_arr),  64'd0);
            chk("rst_absmax", 64'(bus.absmax), 64'd0);
            rst_n = 1'b1;
            edges = -1;
            return;
         end
      end
   endtask

   initial begin
      int edges;
      n_chk  = 0;
      n_fail = 0;

      vt[0] = '{x: mk4(256, 256, 256, 256),       absmax: 16'd256,   k: 24'd32512, q: mkq(127, 127, 127, 127), lat: 33};
      vt[1] = '{x: mk4(256, 512, 768, 1024),      absmax: 16'd1024,  k: 24'd8128,  q: mkq(32, 64, 95, 127),    lat: 33};
      vt[2] = '{x: mk4(640, -896, 1152, -1408),   absmax: 16'd1408,  k: 24'd5911,  q: mkq(58, -81, 104, -127),  lat: 33};
      vt[3] = '{x: mk4(0, 0, 0, 0),               absmax: 16'd0,     k: 24'd0,     q: mkq(0, 0, 0, 0),         lat: 9};
      vt[4] = '{x: mk4(-32768, 16384, 0, -100),   absmax: 16'd32767, k: 24'd254,   q: mkq(-127, 64, 0, 0),     lat: 33};

      rst_n         = 1'b0;
      bus.enable    = 1'b1;
      bus.start     = 1'b0;
      bus.input_arr = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy",   64'(bus.busy),   64'd0);
      chk("reset_done",   64'(bus.done),   64'd0);
      chk("reset_q_arr",  64'(bus.q_arr),  64'd0);
      chk("reset_absmax", 64'(bus.absmax), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 5; i++) begin
         run(vt[i].x, 0, 0, 0, edges);
         chk($sformatf("v%0d_latency", i), 64'(edges),       64'(vt[i].lat));
         chk($sformatf("v%0d_absmax", i),  64'(bus.absmax),  64'(vt[i].absmax));
         chk($sformatf("v%0d_k", i),       64'(dut.r_k),     64'(vt[i].k));
         chk($sformatf("v%0d_q_arr", i),   64'(bus.q_arr),   64'(vt[i].q));
         chk($sformatf("v%0d_busy_done", i), 64'(bus.busy),  64'd0);
      end

      // Results hold in DONE
      repeat (4) @(posedge clk);
      #1;
      chk("hold_done",  64'(bus.done),  64'd1);
      chk("hold_q_arr", 64'(bus.q_arr), 64'(vt[4].q));

      // Enable dropped for 5 cycles mid-divide
      run(vt[2].x, 10, 0, 0, edges);
      chk("pause_latency", 64'(edges),      64'd38);
      chk("pause_absmax",  64'(bus.absmax), 64'(vt[2].absmax));
      chk("pause_q_arr",   64'(bus.q_arr),  64'(vt[2].q));

      // Start pulsed again while busy is ignored
      run(vt[1].x, 0, 3, 0, edges);
      chk("restart_latency", 64'(edges),      64'd33);
      chk("restart_absmax",  64'(bus.absmax), 64'(vt[1].absmax));
      chk("restart_q_arr",   64'(bus.q_arr),  64'(vt[1].q));

      // Reset mid-quantize, then a clean ramp run
      run(vt[0].x, 0, 0, 30, edges);
      chk("rst_returned", 64'(edges), 64'hFFFF_FFFF_FFFF_FFFF);
      run(vt[1].x, 0, 0, 0, edges);
      chk("post_rst_latency", 64'(edges),      64'd33);
      chk("post_rst_absmax",  64'(bus.absmax), 64'(vt[1].absmax));
      chk("post_rst_q_arr",   64'(bus.q_arr),  64'(vt[1].q));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
